sigmoid_top_mul_pipe_fx: RTL and testbench

Parametrised, pipelined fixed-point multiplier for the sigmoid datapath. It replaces the fixed 15x15 unsigned, 4-stage multiplier.
- Adds configurable operand and output widths, pipeline depth, and per-sample signedness.
- Output stage rounds and shifts the product to the output Q-format, then saturates it.
- Adds valid/ready flow control, so it can sit between the polynomial/LUT stages and the output formatter without an external stall controller.

---
 rtl/sigmoid_fx_pkg.sv | 34 +++
 rtl/sigmoid_fx_round_sat.sv | 50 +++++
 rtl/sigmoid_top_mul_pipe_fx.sv | 131 +++++++++++++
 tb/tb_sigmoid_top_mul_pipe_fx.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigmoid_fx_pkg.sv
// Shared constants and helpers for the sigmoid fixed-point datapath blocks.
package sigmoid_fx_pkg;

  // Bit positions inside sign_mode
  localparam int unsigned SM_A = 1;
  localparam int unsigned SM_B = 0;

  // Width of the saturation bounds; results are compared at this width
  localparam int unsigned BOUND_W = 64;

  typedef struct packed {
    logic signed [BOUND_W-1:0] lo;
    logic signed [BOUND_W-1:0] hi;
  } sat_bounds_t;

  // Signed product width when each operand carries one extra sign/zero bit
  function automatic int unsigned prod_width(int unsigned a_w, int unsigned b_w);
    return a_w + b_w + 1;
  endfunction

  // Clip range for an out_w-bit result, two's complement or unsigned
  function automatic sat_bounds_t sat_bounds(int unsigned out_w, logic is_signed);
    sat_bounds_t b;
    if (is_signed) begin
      b.hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      b.lo = -(64'sd1 <<< (out_w - 1));
    end else begin
      b.hi = (64'sd1 <<< out_w) - 64'sd1;
      b.lo = '0;
    end
    return b;
  endfunction

endpackage

// File: rtl/sigmoid_fx_round_sat.sv
// Combinational round-half-up, arithmetic right shift and clip of a signed
// product down to OUT_WIDTH bits, with a flag for clipped results.
module sigmoid_fx_round_sat
  import sigmoid_fx_pkg::*;
#(
  parameter int unsigned P_WIDTH    = 31,
  parameter int unsigned OUT_WIDTH  = 30,
  parameter int unsigned FRAC_SHIFT = 0
) (
  input  logic signed [P_WIDTH-1:0]   p_i,
  input  logic                        is_signed_i,
  output logic        [OUT_WIDTH-1:0] res_o,
  output logic                        sat_o
);

  // One guard bit so the rounding constant can never wrap the sum
  localparam int unsigned R_WIDTH = P_WIDTH + 1;
  localparam int unsigned RND_SH  = (FRAC_SHIFT == 0) ? 0 : FRAC_SHIFT - 1;
  localparam logic [R_WIDTH-1:0] RND =
    (FRAC_SHIFT == 0) ? '0 : (R_WIDTH'(1) << RND_SH);

  logic signed [R_WIDTH-1:0] sum;
  logic signed [R_WIDTH-1:0] r;
  logic signed [BOUND_W-1:0] r_w;
  logic signed [BOUND_W-1:0] lo;
  logic signed [BOUND_W-1:0] hi;
  logic signed [BOUND_W-1:0] clip;
  sat_bounds_t               bnd;

  // Round, shift, then clamp into the output range
  always_comb begin
    sum   = R_WIDTH'(p_i) + $signed(RND);
    r     = sum >>> FRAC_SHIFT;
    r_w   = BOUND_W'(r);
    bnd   = sat_bounds(OUT_WIDTH, is_signed_i);
    lo    = bnd.lo;
    hi    = bnd.hi;
    clip  = r_w;
    sat_o = 1'b0;
    if (r_w > hi) begin
      clip  = hi;
      sat_o = 1'b1;
    end else if (r_w < lo) begin
      clip  = lo;
      sat_o = 1'b1;
    end
    res_o = OUT_WIDTH'(clip);
  end

endmodule

// File: rtl/sigmoid_top_mul_pipe_fx.sv
// Pipelined fixed-point multiplier with per-sample signedness, output
// rounding/saturation and valid/ready flow control with a global stall.
module sigmoid_top_mul_pipe_fx
  import sigmoid_fx_pkg::*;
#(
  parameter int unsigned A_WIDTH    = 15,
  parameter int unsigned B_WIDTH    = 15,
  parameter int unsigned OUT_WIDTH  = 30,
  parameter int unsigned FRAC_SHIFT = 0,
  parameter int unsigned NUM_STAGE  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   din0,
  input  logic [B_WIDTH-1:0]   din1,
  input  logic [1:0]           sign_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 sat,
  output logic                 sat_sticky
);

  localparam int unsigned P_WIDTH = prod_width(A_WIDTH, B_WIDTH);
  // Index of the last product-carrying stage feeding the output register
  localparam int unsigned LAST    = NUM_STAGE - 1;

  logic                        adv;

  logic [A_WIDTH-1:0]          a_q;
  logic [B_WIDTH-1:0]          b_q;
  logic [1:0]                  sm1_q;
  logic                        v1_q;

  logic signed [P_WIDTH-1:0]   p_q  [2:LAST];
  logic [1:0]                  sm_q [2:LAST];
  logic                        v_q  [2:LAST];

  logic signed [P_WIDTH-1:0]   a_ext;
  logic signed [P_WIDTH-1:0]   b_ext;
  logic signed [P_WIDTH-1:0]   prod_d;

  logic [OUT_WIDTH-1:0]        dout_d;
  logic                        sat_d;
  logic [OUT_WIDTH-1:0]        dout_q;
  logic                        sat_q;
  logic                        out_valid_q;
  logic                        sat_sticky_q;

  // Whole pipe moves together; a held output blocks every stage
  assign adv        = ce & (~out_valid_q | out_ready);
  assign in_ready   = adv & reset;

  assign out_valid  = out_valid_q;
  assign dout       = dout_q;
  assign sat        = sat_q;
  assign sat_sticky = sat_sticky_q;

  // Extend each operand by one bit per its mode, then multiply signed
  always_comb begin
    if (sm1_q[SM_A]) begin
      a_ext = P_WIDTH'($signed(a_q));
    end else begin
      a_ext = $signed(P_WIDTH'(a_q));
    end
    if (sm1_q[SM_B]) begin
      b_ext = P_WIDTH'($signed(b_q));
    end else begin
      b_ext = $signed(P_WIDTH'(b_q));
    end
    prod_d = a_ext * b_ext;
  end

  sigmoid_fx_round_sat #(
    .P_WIDTH    (P_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_round_sat (
    .p_i         (p_q[LAST]),
    .is_signed_i (|sm_q[LAST]),
    .res_o       (dout_d),
    .sat_o       (sat_d)
  );

  // Pipeline registers: capture, multiply, delay line, output
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q         <= '0;
      b_q         <= '0;
      sm1_q       <= '0;
      v1_q        <= 1'b0;
      for (int unsigned k = 2; k <= LAST; k++) begin
        p_q[k]  <= '0;
        sm_q[k] <= '0;
        v_q[k]  <= 1'b0;
      end
      dout_q      <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      a_q         <= din0;
      b_q         <= din1;
      sm1_q       <= sign_mode;
      v1_q        <= in_valid;
      p_q[2]      <= prod_d;
      sm_q[2]     <= sm1_q;
      v_q[2]      <= v1_q;
      for (int unsigned k = 3; k <= LAST; k++) begin
        p_q[k]  <= p_q[k-1];
        sm_q[k] <= sm_q[k-1];
        v_q[k]  <= v_q[k-1];
      end
      dout_q      <= dout_d;
      sat_q       <= sat_d & v_q[LAST];
      out_valid_q <= v_q[LAST];
    end
  end

  // Remember any clipped result that was actually handed downstream
  always_ff @(posedge clk) begin
    if (!reset) begin
      sat_sticky_q <= 1'b0;
    end else if (ce & out_valid_q & out_ready & sat_q) begin
      sat_sticky_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sigmoid_top_mul_pipe_fx.sv
// Scoreboard bench: lane 0 uses the default configuration, lane 1 a Q8.8
// signed configuration with a deeper pipe.
module tb_sigmoid_top_mul_pipe_fx;

  localparam int unsigned AW0 = 15, OW0 = 30, FS0 = 0, NS0 = 4;
  localparam int unsigned AW1 = 16, OW1 = 16, FS1 = 8, NS1 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ce;
  logic        iv   [2];
  logic [15:0] a    [2];
  logic [15:0] b    [2];
  logic [1:0]  sm   [2];
  logic        ordy [2];

  logic irdy0, irdy1, ov0, ov1, sat0, sat1, stk0, stk1;
  logic [OW0-1:0] dout0;
  logic [OW1-1:0] dout1;

  logic        irdy [2];
  logic        ov   [2];
  logic        osat [2];
  logic        stk  [2];
  logic [63:0] dw   [2];

  always_comb begin
    irdy[0] = irdy0; irdy[1] = irdy1;
    ov[0]   = ov0;   ov[1]   = ov1;
    osat[0] = sat0;  osat[1] = sat1;
    stk[0]  = stk0;  stk[1]  = stk1;
    dw[0]   = 64'(dout0);
    dw[1]   = 64'(dout1);
  end

  sigmoid_top_mul_pipe_fx #(
    .A_WIDTH(AW0), .B_WIDTH(AW0), .OUT_WIDTH(OW0), .FRAC_SHIFT(FS0), .NUM_STAGE(NS0)
  ) dut0 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(iv[0]), .in_ready(irdy0),
    .din0(a[0][14:0]), .din1(b[0][14:0]), .sign_mode(sm[0]),
    .out_valid(ov0), .out_ready(ordy[0]), .dout(dout0), .sat(sat0), .sat_sticky(stk0)
  );

  sigmoid_top_mul_pipe_fx #(
    .A_WIDTH(AW1), .B_WIDTH(AW1), .OUT_WIDTH(OW1), .FRAC_SHIFT(FS1), .NUM_STAGE(NS1)
  ) dut1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(iv[1]), .in_ready(irdy1),
    .din0(a[1]), .din1(b[1]), .sign_mode(sm[1]),
    .out_valid(ov1), .out_ready(ordy[1]), .dout(dout1), .sat(sat1), .sat_sticky(stk1)
  );

  typedef struct {
    logic [63:0] d;
    logic        s;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic sticky_m [2];
  logic pend     [2];
  logic [63:0] hold_d [2];
  logic hold_s   [2];
  logic rdone;

  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endfunction

  // Reference: plain integer arithmetic on the mathematical operand values
  function automatic exp_t ref_model(int aw, int ow, int fs, longint ar, longint br, logic [1:0] s);
    exp_t   e;
    longint av, bv, p, r, lo, hi;
    av = ar;
    bv = br;
    if (s[1] && ((ar >> (aw - 1)) & 1) == 1) av = ar - (64'sd1 <<< aw);
    if (s[0] && ((br >> (aw - 1)) & 1) == 1) bv = br - (64'sd1 <<< aw);
    p = av * bv;
    if (fs > 0) p = p + (64'sd1 <<< (fs - 1));
    r = p >>> fs;
    if (s != 2'b00) begin
      hi = (64'sd1 <<< (ow - 1)) - 1;
      lo = -(64'sd1 <<< (ow - 1));
    end else begin
      hi = (64'sd1 <<< ow) - 1;
      lo = 0;
    end
    e.s = 1'b0;
    if (r > hi) begin r = hi; e.s = 1'b1; end
    else if (r < lo) begin r = lo; e.s = 1'b1; end
    e.d = 64'(r & ((64'sd1 <<< ow) - 1));
    return e;
  endfunction

  // Expected results enter the scoreboard at the accepting edge
  always @(negedge clk) begin
    if (!reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (iv[0] && irdy[0]) q0.push_back(ref_model(AW0, OW0, FS0, 64'(a[0][14:0]), 64'(b[0][14:0]), sm[0]));
      if (iv[1] && irdy[1]) q1.push_back(ref_model(AW1, OW1, FS1, 64'(a[1]), 64'(b[1]), sm[1]));
    end
  end

  // Monitor: flow-control rule, output hold, sticky flag and result order
  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      exp_t e;
      logic empty;
      chk($sformatf("in_ready_l%0d", l), longint'(irdy[l]),
          longint'(reset & ce & (~ov[l] | ordy[l])));
      if (reset) begin
        if (pend[l]) begin
          chk($sformatf("hold_valid_l%0d", l), longint'(ov[l]), 1);
          chk($sformatf("hold_dout_l%0d", l), longint'(dw[l]), longint'(hold_d[l]));
          chk($sformatf("hold_sat_l%0d", l), longint'(osat[l]), longint'(hold_s[l]));
        end
        chk($sformatf("sat_sticky_l%0d", l), longint'(stk[l]), longint'(sticky_m[l]));
        if (ce && ov[l] && ordy[l]) begin
          empty = (l == 0) ? (q0.size() == 0) : (q1.size() == 0);
          if (empty) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output_l%0d: got dout 0x%0h expected none at %0t", l, dw[l], $time);
          end else begin
            if (l == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("dout_l%0d", l), longint'(dw[l]), longint'(e.d));
            chk($sformatf("sat_l%0d", l), longint'(osat[l]), longint'(e.s));
            sticky_m[l] = sticky_m[l] | e.s;
          end
        end
        pend[l]   = ov[l] && !(ce && ordy[l]);
        hold_d[l] = dw[l];
        hold_s[l] = osat[l];
      end else begin
        pend[l]     = 1'b0;
        sticky_m[l] = 1'b0;
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one operand pair and hold it until it is accepted
  task automatic send(int l, logic [15:0] av, logic [15:0] bv, logic [1:0] s);
    int w;
    iv[l] = 1'b1; a[l] = av; b[l] = bv; sm[l] = s;
    w = 0;
    forever begin
      @(negedge clk);
      if (irdy[l]) break;
      w++;
      if (w > 500) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout_l%0d: got no accept expected accept within 500 cycles", l);
        break;
      end
    end
    @(posedge clk);
    #1;
    iv[l] = 1'b0;
  endtask

  // Count cycles from the accepting edge until out_valid rises
  task automatic wait_out(int l, int exp_lat, string nm);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov[l] && lat < 60);
    chk({nm, "_latency"}, lat, exp_lat);
  endtask

  function automatic logic [15:0] pick(int l);
    logic [15:0] m;
    m = (l == 0) ? 16'h7FFF : 16'hFFFF;
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return m;
      2:       return (m >> 1) + 16'd1;
      3:       return m >> 1;
      default: return 16'($urandom) & m;
    endcase
  endfunction

  task automatic stream(int l, int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] x, y;
      x = pick(l);
      y = pick(l);
      send(l, x, y, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  initial begin
    int pat [5];
    int w;
    logic fz;
    pat = '{0, 1, 1, 1, 0};
    reset = 1'b0; ce = 1'b1; rdone = 1'b0;
    for (int l = 0; l < 2; l++) begin
      iv[l] = 1'b0; a[l] = '0; b[l] = '0; sm[l] = '0; ordy[l] = 1'b1;
      sticky_m[l] = 1'b0; pend[l] = 1'b0; hold_d[l] = '0; hold_s[l] = 1'b0;
    end
    idle(3);
    chk("reset_out_valid_l0", longint'(ov[0]), 0);
    chk("reset_dout_l0", longint'(dw[0]), 0);
    chk("reset_sticky_l1", longint'(stk[1]), 0);
    reset = 1'b1;
    idle(2);

    // Full-scale unsigned, legacy-exact
    send(0, 16'h7FFF, 16'h7FFF, 2'b00);
    wait_out(0, NS0, "t1");
    chk("t1_dout", longint'(dw[0]), 64'h3FFF0001);
    chk("t1_sat", longint'(osat[0]), 0);
    idle(1);
    idle(3);

    // Back-to-back samples leave on consecutive cycles
    send(0, 16'd2, 16'd3, 2'b00);
    send(0, 16'd4, 16'd5, 2'b00);
    send(0, 16'd6, 16'd7, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t2_valid_c%0d", i), longint'(ov[0]), pat[i]);
    end
    idle(3);

    // Backpressure while the output is valid
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, 16'(100 + i), 16'(7 + i), 2'b00);
      end
      begin
        w = 0;
        do begin @(negedge clk); w++; end while (!ov[0] && w < 50);
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        idle(3);
        ordy[0] = 1'b1;
      end
    join
    idle(10);

    // Q8.8 signed lane: product, round-up and saturation
    send(1, 16'h0180, 16'hFF00, 2'b11);
    wait_out(1, NS1, "t4a");
    chk("t4a_dout", longint'(dw[1]), 64'hFE80);
    chk("t4a_sat", longint'(osat[1]), 0);
    idle(1);
    send(1, 16'h0001, 16'h0080, 2'b11);
    wait_out(1, NS1, "t4b");
    chk("t4b_dout", longint'(dw[1]), 64'h0001);
    idle(1);
    send(1, 16'h7FFF, 16'h7FFF, 2'b11);
    wait_out(1, NS1, "t4c");
    chk("t4c_dout", longint'(dw[1]), 64'h7FFF);
    chk("t4c_sat", longint'(osat[1]), 1);
    idle(2);
    chk("t4_sticky", longint'(stk[1]), 1);

    // Reset with samples in flight discards them
    send(0, 16'd11, 16'd13, 2'b00);
    send(0, 16'd17, 16'd19, 2'b01);
    send(0, 16'd23, 16'd29, 2'b10);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_out_valid", longint'(ov[0]), 0);
    chk("t5_sticky_l1", longint'(stk[1]), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("t5_quiet_c%0d", i), longint'(ov[0]), 0);
    end
    idle(1);

    // Clock-enable freeze with two samples in flight
    send(0, 16'h1234, 16'h0042, 2'b00);
    send(0, 16'h7000, 16'h4001, 2'b11);
    idle(1);
    ce = 1'b0;
    @(negedge clk);
    fz = ov[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t6_frozen_c%0d", i), longint'(ov[0]), longint'(fz));
    end
    idle(1);
    ce = 1'b1;
    idle(10);

    // Randomized traffic on both lanes with random stalls
    fork
      begin
        fork
          stream(0, 150);
          stream(1, 150);
        join
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1;
          ordy[0] = ($urandom_range(0, 3) != 0);
          ordy[1] = ($urandom_range(0, 3) != 0);
          ce      = ($urandom_range(0, 9) != 0);
        end
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        ce      = 1'b1;
      end
    join

    w = 0;
    while ((q0.size() != 0 || q1.size() != 0) && w < 100) begin
      idle(1);
      w++;
    end
    idle(2);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
